// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Shares one 8-bit barrel shifter (0..7 per pass, LSL/LSR/ASR) between two
//   requesters. Commands are arbitrated round-robin. Shift amounts above 7 are
//   split into successive passes of at most 7. Each command produces exactly
//   one tagged response on a valid/ready channel.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   reqN_valid/ready            command handshake per requester (ready is combinational)
//   reqN_data/amt/mode          operand, total shift amount, mode
//                               (00 LSL, 01 LSR, 10 ASR, 11 pass-through)
//   rsp_valid/ready             response handshake
//   rsp_data/cout/id            result, last bit shifted out, requester index
//   busy                        high whenever the controller is not idle
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_mode,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_mode,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int unsigned      STEP_W   = 3;
  localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_LSL  = 2'b00,
    MODE_LSR  = 2'b01,
    MODE_ASR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_t;

  state_t            state;
  logic              ptr;      // round-robin pointer: side that wins a tie
  logic [WIDTH-1:0]  acc;
  logic [AMT_W-1:0]  rem;
  mode_t             mode_r;
  logic              id_r;
  logic              cout_r;

  logic              grant0;
  logic              grant1;

  logic [STEP_W-1:0] step;
  logic [WIDTH:0]    lsl_ext;
  logic [WIDTH:0]    lsr_ext;
  logic [WIDTH:0]    asr_ext;
  logic [WIDTH-1:0]  sh_data;
  logic              sh_cout;
  logic [AMT_W-1:0]  rem_next;
  logic              last_pass;

  // Arbitration: only offered while idle and out of reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == S_IDLE) begin
      if (req0_valid && (!req1_valid || !ptr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // One shifter pass. The operand is widened by one bit on the side the data
  // leaves from, so the bit shifted out lands in that extra position; a step
  // of zero then naturally yields a carry of 0.
  always_comb begin
    step = '0;
    if (mode_r != MODE_PASS) begin
      step = (rem > MAX_STEP) ? STEP_W'(7) : rem[STEP_W-1:0];
    end

    lsl_ext = {1'b0, acc} << step;
    lsr_ext = {acc, 1'b0} >> step;
    asr_ext = $unsigned($signed({acc, 1'b0}) >>> step);

    sh_data = acc;
    sh_cout = 1'b0;
    case (mode_r)
      MODE_LSL: begin
        sh_data = lsl_ext[WIDTH-1:0];
        sh_cout = lsl_ext[WIDTH];
      end
      MODE_LSR: begin
        sh_data = lsr_ext[WIDTH:1];
        sh_cout = lsr_ext[0];
      end
      MODE_ASR: begin
        sh_data = asr_ext[WIDTH:1];
        sh_cout = asr_ext[0];
      end
      default: begin
        sh_data = acc;
        sh_cout = 1'b0;
      end
    endcase

    rem_next  = rem - AMT_W'(step);
    // Pass-through always finishes after its single pass, whatever the amount.
    last_pass = (mode_r == MODE_PASS) || (rem_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      mode_r    <= MODE_LSL;
      id_r      <= 1'b0;
      cout_r    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            acc    <= grant1 ? req1_data : req0_data;
            rem    <= grant1 ? req1_amt  : req0_amt;
            mode_r <= mode_t'(grant1 ? req1_mode : req0_mode);
            id_r   <= grant1;
            ptr    <= grant0;   // next tie goes to the side not just served
            cout_r <= 1'b0;
            state  <= S_SHIFT;
            busy   <= 1'b1;
          end
        end

        S_SHIFT: begin
          acc <= sh_data;
          rem <= rem_next;
          if (step != '0) begin
            cout_r <= sh_cout;
          end
          // Response registers load on the final pass so rsp_valid rises
          // together with the transition into DONE.
          if (last_pass) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= sh_data;
            rsp_cout  <= (step != '0) ? sh_cout : cout_r;
            rsp_id    <= id_r;
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed commands with hand-computed results,
// a scoreboard queue filled on acceptance and drained by a response monitor.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [3:0] req0_amt;
  logic [1:0] req0_mode;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [3:0] req1_amt;
  logic [1:0] req1_mode;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cout;
  logic       rsp_id;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       cout;
    logic       id;
    int         passes;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 5000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Present one command on requester r and hold it until accepted.
  task automatic send(input int r, input logic [7:0] d, input logic [3:0] a,
                      input logic [1:0] m, input logic [7:0] ed, input logic ec,
                      input int p, input bit push);
    int   t;
    bit   got;
    exp_t e;
    @(negedge clk);
    if (r == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
    end
    got = 1'b0;
    t   = 0;
    while (!got && t < 200) begin
      #1;
      if ((r == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        grants.push_back(r);
        if (push) begin
          e.data    = ed;
          e.cout    = ec;
          e.id      = r[0];
          e.passes  = p;
          e.acc_cyc = cyc;
          sb.push_back(e);
        end
      end
      @(negedge clk);
      t++;
    end
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL grant_timeout req%0d: no ready seen, required within 200 cycles", r);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || busy || rsp_valid) && t < 100) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: pending=%0d busy=%0b, required idle within 100 cycles",
               sb.size(), busy);
    end
  endtask

  // Response monitor.
  initial begin : monitor
    bit   prev_valid;
    int   first_cyc;
    exp_t e;
    prev_valid = 1'b0;
    first_cyc  = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        check("ready_exclusive", 32'(req0_ready && req1_ready), 32'(0));
        if (rsp_valid) begin
          if (!prev_valid) first_cyc = cyc;
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_rsp: got data 0x%0h id %0b, required no response",
                     rsp_data, rsp_id);
          end else begin
            e = sb[0];
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            check("rsp_id",   32'(rsp_id),   32'(e.id));
            check("busy_in_done",  32'(busy), 32'(1));
            check("ready_in_done", 32'({req0_ready, req1_ready}), 32'(0));
            if (rsp_ready) begin
              check("latency", 32'(first_cyc - e.acc_cyc), 32'(e.passes + 1));
              e = sb.pop_front();
            end
          end
        end
        prev_valid = rsp_valid && !rsp_ready;
      end
    end
  end

  initial begin : stimulus
    int t;
    int exp_g[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};

    rst        = 1'b1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h00; req0_amt = 4'd0; req0_mode = 2'b00;
    req1_valid = 1'b1; req1_data = 8'h00; req1_amt = 4'd0; req1_mode = 2'b00;

    // Readys stay low while reset is asserted, even with both requesters valid.
    repeat (3) begin
      @(negedge clk); #2;
      check("ready_in_rst", 32'({req0_ready, req1_ready}), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data",  32'(rsp_data),  32'(0));
    check("rst_rsp_cout",  32'(rsp_cout),  32'(0));
    check("rst_rsp_id",    32'(rsp_id),    32'(0));
    check("rst_busy",      32'(busy),      32'(0));

    // Both requesters continuously busy from reset: grants alternate 0,1,...
    fork
      begin
        send(0, 8'h81, 4'd1,  2'b00, 8'h02, 1'b1, 1, 1'b1);
        send(0, 8'hFF, 4'd15, 2'b00, 8'h00, 1'b0, 3, 1'b1);
        send(0, 8'hA5, 4'd0,  2'b01, 8'hA5, 1'b0, 1, 1'b1);
      end
      begin
        send(1, 8'h80, 4'd10, 2'b10, 8'hFF, 1'b1, 2, 1'b1);
        send(1, 8'h5A, 4'd9,  2'b11, 8'h5A, 1'b0, 1, 1'b1);
        send(1, 8'h81, 4'd8,  2'b01, 8'h00, 1'b1, 2, 1'b1);
      end
    join
    wait_idle();

    // Consumer stalls 5 cycles in DONE while req1 waits.
    rsp_ready = 1'b0;
    send(0, 8'h3E, 4'd2, 2'b01, 8'h0F, 1'b1, 1, 1'b1);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= 20) begin
      compared++;
      mismatched++;
      $display("FAIL stall_rsp_timeout: rsp_valid %0b, required 1 within 20 cycles", rsp_valid);
    end
    fork
      send(1, 8'h90, 4'd4, 2'b10, 8'hF9, 1'b0, 1, 1'b1);
      begin
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset during the second pass of an amt-14 command discards it.
    send(0, 8'hFF, 4'd14, 2'b00, 8'h00, 1'b0, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_busy",      32'(busy),      32'(0));

    // Pointer is back on req0 after reset.
    fork
      send(0, 8'h40, 4'd7, 2'b10, 8'h00, 1'b1, 1, 1'b1);
      send(1, 8'h01, 4'd7, 2'b00, 8'h80, 1'b0, 1, 1'b1);
    join
    wait_idle();

    check("grant_count", 32'(grants.size()), 32'(11));
    for (int i = 0; i < 11; i++) begin
      if (i < grants.size()) check($sformatf("grant_order[%0d]", i), 32'(grants[i]), 32'(exp_g[i]));
    end
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Shared-resource controller for the 8-bit combinational barrel shifter (3-bit shift amount, LSL/LSR/ASR modes).
- Arbitrates between two requesters using round-robin priority.
- Decomposes shift amounts larger than 7 into sequential passes of at most 7 through a single internal shifter instance.
- Returns one tagged response per command over a valid/ready channel.

Parameters:
- WIDTH, 8: data width. Fixed at 8 for this revision, because the per-pass shift field is 3 bits.
- AMT_W, 4: width of the requested shift amount. Legal amounts are 0..2^AMT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 presents a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_data  in  WIDTH  operand.
- req0_amt  in  AMT_W  total shift amount.
- req0_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 pass-through.
- req1_valid, req1_ready, req1_data, req1_amt, req1_mode: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  shifted result.
- rsp_cout  out  1  last bit shifted out.
- rsp_id  out  1  index of the requester that issued the command.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- Reset: state=IDLE, rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_id=0, busy=0, priority pointer selects req0. req0_ready and req1_ready are 0 while rst is high.
- reqN_ready is combinational. It is high only in IDLE, with rst low, reqN_valid high, and N winning arbitration. At most one ready is high per cycle.
- Arbitration:
  - Only one valid → grant it.
  - Both valid → grant the pointer side.
  - After each grant, the pointer moves to the other requester.
  - Requests are never granted outside IDLE; requesters hold valid and payload until ready.
- Accept (IDLE, grant): latch data into acc, amt into rem, plus mode and id. Clear cout_r. Go to SHIFT.
- SHIFT, one pass per cycle:
  - step = min(rem,7).
  - acc <= shifter(acc, step, mode).
  - rem <= rem - step.
  - cout_r <= shifter cout when step != 0; otherwise cout_r is unchanged.
  - If rem - step == 0, go to DONE.
  - amt=0 takes exactly one pass with step 0: acc unchanged, cout 0.
- Mode 11: exactly one pass. acc unchanged, cout_r=0, regardless of amt.
- Pass count P:
  - P = max(1, ceil(amt/7)) for modes 00–10; P = 1 for mode 11.
  - amt 0..7 → P=1, 8..14 → P=2, 15 → P=3.
- Shifter semantics per pass:
  - LSL: cout = acc[WIDTH-step].
  - LSR and ASR: cout = acc[step-1].
  - ASR sign-fills.
  - LSL/LSR results become 0 once the cumulative amount is ≥ WIDTH.
  - ASR result saturates to all sign bits.
- DONE:
  - rsp_valid=1. rsp_data, rsp_cout, rsp_id are registered copies of acc, cout_r, id; stable while rsp_valid && !rsp_ready.
  - On rsp_ready, rsp_valid drops next cycle and state returns to IDLE.
  - A new grant is possible in the first IDLE cycle.
- Latency: command accepted at edge T → rsp_valid high from cycle T+1+P. Throughput is one command per P+2 cycles minimum.
- Reset mid-operation: the in-flight command is discarded, no response is issued, and the pointer returns to req0.
- Simultaneous new valid while in DONE with rsp_ready: the new request is not accepted until the next IDLE cycle.

Test Plan:
- After reset, req0 sends LSL data 0x81, amt 1 → req0_ready high in the accept cycle. rsp_valid 2 cycles later; rsp_data 0x02, rsp_cout 1, rsp_id 0.
- req1 sends ASR data 0x80, amt 10 → 2 passes (7, then 3). rsp_valid 3 cycles after accept; rsp_data 0xFF, rsp_cout 1, rsp_id 1.
- req0 sends LSL data 0xFF, amt 15 → 3 passes. rsp_valid 4 cycles after accept; rsp_data 0x00, rsp_cout 0. Separately, mode 11 with data 0x5A, amt 9 → 0x5A, cout 0, 1 pass.
- req0 and req1 both valid from reset: req0 is granted first (rsp_id 0), then req1 (rsp_id 1). With both held valid continuously, grants alternate 0,1,0,1.
- rsp_ready held low for 5 cycles in DONE → rsp_data/cout/id constant, busy=1, both readys 0. One response is consumed when rsp_ready rises.
- rst pulsed during the second SHIFT pass of an amt-14 command → next cycle: rsp_valid 0, busy 0, no response emitted. A subsequent simultaneous request is granted to req0.
